// File: rtl/rename_pkg.sv
// rename_pkg: shared types and default sizes for the rename/dispatch stage.
//   Def* constants size the packet and table types; parameter overrides on
//   rename_dispatch_stage must be made together with these constants.
package rename_pkg;

    localparam int unsigned DefXlen        = 32;
    localparam int unsigned DefNumArchRegs = 32;
    localparam int unsigned DefTagW        = 6;
    localparam int unsigned DefNumQueues   = 4;
    localparam int unsigned DefNumTags     = 2 ** DefTagW;

    typedef logic [DefTagW-1:0] tag_t;
    typedef logic [DefXlen-1:0] data_t;

    // Register status table entry: valid means the register awaits this tag.
    typedef struct packed {
        logic valid;
        tag_t tag;
    } rst_entry_t;

    // Resolved source operand: rdy=1 -> data is meaningful, else tag is.
    typedef struct packed {
        logic  rdy;
        tag_t  tag;
        data_t data;
    } src_t;

    typedef struct packed {
        src_t  rs1;
        src_t  rs2;
        tag_t  rd_tag;
        logic  rd_we;
        data_t imm;
    } disp_pkt_t;

    typedef enum logic [1:0] {
        QInt  = 2'd0,
        QLdst = 2'd1,
        QMul  = 2'd2,
        QDiv  = 2'd3
    } queue_e;

    typedef enum logic [1:0] {
        StRun,
        StBrWait,
        StRedirect
    } disp_state_e;

endpackage

// File: rtl/tag_free_list.sv
// tag_free_list: circular FIFO of free rename tags, depth 2**TAG_W.
//   Comes out of reset full, holding tags 0..Depth-1 in ascending order.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i, push_tag_i return a tag to the list
//   pop_i, pop_tag_o   take the head tag (pop_tag_o valid whenever not empty)
//   empty_o, full_o    occupancy flags
//   count_o            number of free tags held
module tag_free_list
    import rename_pkg::*;
#(
    parameter int unsigned TAG_W = DefTagW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [TAG_W-1:0] push_tag_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] pop_tag_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [TAG_W:0]   count_o
);

    localparam int unsigned Depth = 2 ** TAG_W;

    logic [TAG_W-1:0] mem_q [Depth];
    logic [TAG_W-1:0] rd_ptr_q;
    logic [TAG_W-1:0] wr_ptr_q;
    logic [TAG_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (TAG_W+1)'(Depth));
    assign count_o   = count_q;
    assign pop_tag_o = mem_q[rd_ptr_q];

    // Pop never bypasses a same-cycle push: an empty list simply refuses.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= TAG_W'(i);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= (TAG_W+1)'(Depth);
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_tag_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rename_dispatch_stage.sv
// rename_dispatch_stage: renames rd through a tag free list and register status
//   table (RST), resolves rs1/rs2 to a tag or data, and emits one registered
//   dispatch packet per cycle into one of NUM_QUEUES issue queues. A branch
//   holds dispatch until its CDB resolution; taken branches and jumps pulse
//   an IFQ redirect.
// Configuration:
//   RENAME_CDB_BYPASS_EN  when defined, a source whose pending tag is on the CDB
//                         in the lookup cycle takes the CDB data; when undefined
//                         that case stalls one cycle and re-reads the regfile.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   ifq_valid_i / ifq_ren_o           IFQ handshake (ifq_ren_o = fire)
//   dec_*_i                           decoded instruction fields
//   queue_full_i                      per-queue full
//   rf_raddr1/2_o, rf_rdata1/2_i      combinational regfile read
//   rf_we_o, rf_waddr_o               regfile write of cdb_data on retire of latest tag
//   cdb_*_i                           common data bus and branch resolution
//   disp_valid_o, disp_pkt_o          registered one-hot dispatch and packet
//   redirect_valid_o, redirect_addr_o 1-cycle redirect pulse and held target
module rename_dispatch_stage
    import rename_pkg::*;
#(
    parameter int unsigned XLEN          = DefXlen,
    parameter int unsigned NUM_ARCH_REGS = DefNumArchRegs,
    parameter int unsigned TAG_W         = DefTagW,
    parameter int unsigned NUM_QUEUES    = DefNumQueues,
    localparam int unsigned RegW         = $clog2(NUM_ARCH_REGS),
    localparam int unsigned QselW        = $clog2(NUM_QUEUES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ifq_valid_i,
    output logic                  ifq_ren_o,
    input  logic [RegW-1:0]       dec_rs1_i,
    input  logic [RegW-1:0]       dec_rs2_i,
    input  logic [RegW-1:0]       dec_rd_i,
    input  logic                  dec_rd_we_i,
    input  logic [QselW-1:0]      dec_qsel_i,
    input  logic [XLEN-1:0]       dec_imm_i,
    input  logic                  dec_branch_i,
    input  logic                  dec_jump_i,
    input  logic [XLEN-1:0]       dec_target_i,
    input  logic [NUM_QUEUES-1:0] queue_full_i,
    output logic [RegW-1:0]       rf_raddr1_o,
    output logic [RegW-1:0]       rf_raddr2_o,
    input  logic [XLEN-1:0]       rf_rdata1_i,
    input  logic [XLEN-1:0]       rf_rdata2_i,
    output logic                  rf_we_o,
    output logic [RegW-1:0]       rf_waddr_o,
    input  logic                  cdb_valid_i,
    input  logic [TAG_W-1:0]      cdb_tag_i,
    input  logic [XLEN-1:0]       cdb_data_i,
    input  logic                  cdb_branch_i,
    input  logic                  cdb_taken_i,
    output logic [NUM_QUEUES-1:0] disp_valid_o,
    output disp_pkt_t             disp_pkt_o,
    output logic                  redirect_valid_o,
    output logic [XLEN-1:0]       redirect_addr_o
);

    rst_entry_t            rst_q [NUM_ARCH_REGS];
    disp_state_e           state_q;
    logic [NUM_QUEUES-1:0] disp_valid_q;
    disp_pkt_t             disp_pkt_q;
    disp_pkt_t             disp_pkt_d;
    logic                  redirect_valid_q;
    logic [XLEN-1:0]       redirect_addr_q;

    logic                  cdb_free;
    logic                  cdb_hit;
    logic [RegW-1:0]       cdb_hit_reg;
    logic                  alloc;
    logic                  fire;
    logic                  hazard_stall;

    logic [RegW-1:0]       src_addr [2];
    logic [XLEN-1:0]       src_rf   [2];
    src_t                  src      [2];
    logic [1:0]            src_hz;

    logic                  fl_pop;
    logic [TAG_W-1:0]      fl_pop_tag;
    logic                  fl_empty;
    logic                  fl_full;
    logic [TAG_W:0]        fl_count;
    logic                  unused_fl;

    // Branch resolutions carry no rename tag, so only plain results free tags.
    assign cdb_free = cdb_valid_i & ~cdb_branch_i;

    assign src_addr[0] = dec_rs1_i;
    assign src_addr[1] = dec_rs2_i;
    assign src_rf[0]   = rf_rdata1_i;
    assign src_rf[1]   = rf_rdata2_i;
    assign rf_raddr1_o = dec_rs1_i;
    assign rf_raddr2_o = dec_rs2_i;

    always_comb begin
        rst_entry_t ent;
        ent    = '0;
        src_hz = '0;
        for (int s = 0; s < 2; s++) begin
            src[s] = '0;
            ent    = rst_q[src_addr[s]];
            if (src_addr[s] == '0) begin
                src[s].rdy = 1'b1;
            end else if (ent.valid) begin
                if (cdb_free && (ent.tag == cdb_tag_i)) begin
`ifdef RENAME_CDB_BYPASS_EN
                    src[s].rdy  = 1'b1;
                    src[s].data = cdb_data_i;
`else
                    // Regfile is written this cycle; look again next cycle.
                    src_hz[s] = 1'b1;
`endif
                end else begin
                    src[s].tag = ent.tag;
                end
            end else begin
                src[s].rdy  = 1'b1;
                src[s].data = src_rf[s];
            end
        end
    end

`ifndef RENAME_CDB_BYPASS_EN
    logic unused_cdb_data;
    assign unused_cdb_data = ^cdb_data_i;
`endif

    assign hazard_stall = |src_hz;

    // Tags are unique in flight, so at most one RST entry can match the CDB.
    always_comb begin
        cdb_hit     = 1'b0;
        cdb_hit_reg = '0;
        for (int r = 1; r < NUM_ARCH_REGS; r++) begin
            if (cdb_free && rst_q[r].valid && (rst_q[r].tag == cdb_tag_i)) begin
                cdb_hit     = 1'b1;
                cdb_hit_reg = RegW'(r);
            end
        end
    end

    assign rf_we_o    = cdb_hit & ~rst_i;
    assign rf_waddr_o = cdb_hit_reg;

    assign alloc = dec_rd_we_i & (dec_rd_i != '0);
    assign fire  = ~rst_i & ifq_valid_i & (state_q == StRun) & ~queue_full_i[dec_qsel_i]
                 & ~(alloc & fl_empty) & ~hazard_stall;
    assign fl_pop    = fire & alloc;
    assign ifq_ren_o = fire;

    tag_free_list #(
        .TAG_W (TAG_W)
    ) u_free_list (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (cdb_free),
        .push_tag_i (cdb_tag_i),
        .pop_i      (fl_pop),
        .pop_tag_o  (fl_pop_tag),
        .empty_o    (fl_empty),
        .full_o     (fl_full),
        .count_o    (fl_count)
    );

    assign unused_fl = ^{fl_full, fl_count};

    // Later assignment wins: a same-cycle rename of rd overrides the CDB clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                rst_q[r] <= '0;
            end
        end else begin
            if (cdb_hit) begin
                rst_q[cdb_hit_reg].valid <= 1'b0;
            end
            if (fl_pop) begin
                rst_q[dec_rd_i] <= {1'b1, fl_pop_tag};
            end
        end
    end

    always_comb begin
        disp_pkt_d        = '0;
        disp_pkt_d.rs1    = src[0];
        disp_pkt_d.rs2    = src[1];
        disp_pkt_d.rd_tag = alloc ? fl_pop_tag : '0;
        disp_pkt_d.rd_we  = alloc;
        disp_pkt_d.imm    = dec_imm_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_valid_q <= '0;
            disp_pkt_q   <= '0;
        end else begin
            disp_valid_q <= '0;
            if (fire) begin
                disp_valid_q[dec_qsel_i] <= 1'b1;
                disp_pkt_q               <= disp_pkt_d;
            end
        end
    end

    // redirect_valid_q is high exactly while in StRedirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= StRun;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (fire && dec_branch_i) begin
                        state_q         <= StBrWait;
                        redirect_addr_q <= dec_target_i;
                    end else if (fire && dec_jump_i) begin
                        state_q          <= StRedirect;
                        redirect_valid_q <= 1'b1;
                        redirect_addr_q  <= dec_target_i;
                    end
                end
                StBrWait: begin
                    if (cdb_valid_i && cdb_branch_i) begin
                        if (cdb_taken_i) begin
                            state_q          <= StRedirect;
                            redirect_valid_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRedirect: state_q <= StRun;
                default:    state_q <= StRun;
            endcase
        end
    end

    assign disp_valid_o     = disp_valid_q;
    assign disp_pkt_o       = disp_pkt_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_addr_o  = redirect_addr_q;

endmodule

// File: tb/tb_rename_dispatch_stage.sv
// Bench for rename_dispatch_stage: directed vector table, hand-written corner
// sequences and a randomized run, all scored against a queue/array model.
module tb_rename_dispatch_stage;
    import rename_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifq_valid;
    logic        ifq_ren;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rd_we;
    logic [1:0]  dec_qsel;
    logic [31:0] dec_imm;
    logic        dec_branch, dec_jump;
    logic [31:0] dec_target;
    logic [3:0]  queue_full;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_branch, cdb_taken;
    logic [3:0]  disp_valid;
    disp_pkt_t   disp_pkt;
    logic        redirect_valid;
    logic [31:0] redirect_addr;

    always #5 clk = ~clk;

    rename_dispatch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ifq_valid_i      (ifq_valid),
        .ifq_ren_o        (ifq_ren),
        .dec_rs1_i        (dec_rs1),
        .dec_rs2_i        (dec_rs2),
        .dec_rd_i         (dec_rd),
        .dec_rd_we_i      (dec_rd_we),
        .dec_qsel_i       (dec_qsel),
        .dec_imm_i        (dec_imm),
        .dec_branch_i     (dec_branch),
        .dec_jump_i       (dec_jump),
        .dec_target_i     (dec_target),
        .queue_full_i     (queue_full),
        .rf_raddr1_o      (rf_raddr1),
        .rf_raddr2_o      (rf_raddr2),
        .rf_rdata1_i      (rf_rdata1),
        .rf_rdata2_i      (rf_rdata2),
        .rf_we_o          (rf_we),
        .rf_waddr_o       (rf_waddr),
        .cdb_valid_i      (cdb_valid),
        .cdb_tag_i        (cdb_tag),
        .cdb_data_i       (cdb_data),
        .cdb_branch_i     (cdb_branch),
        .cdb_taken_i      (cdb_taken),
        .disp_valid_o     (disp_valid),
        .disp_pkt_o       (disp_pkt),
        .redirect_valid_o (redirect_valid),
        .redirect_addr_o  (redirect_addr)
    );

    // External regfile, written by the model's view of each retire.
    logic [31:0] rf_mem [32];
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    int checks = 0;
    int errors = 0;

    // Reference model: RST as "pending tag or -1", free list and in-flight
    // tags as queues, dispatcher mode 0 run / 1 wait-branch / 2 redirect.
    int          m_rst [32];
    int          m_fl[$];
    int          inflight[$];
    int          m_mode;
    logic [31:0] m_redir_addr;

    logic        obs_ren, obs_rf_we;
    logic [4:0]  obs_rf_waddr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_rst[r] = -1;
        m_fl.delete();
        for (int t = 0; t < 64; t++) m_fl.push_back(t);
        inflight.delete();
        m_mode       = 0;
        m_redir_addr = '0;
    endtask

    task automatic set_idle();
        ifq_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_we = 0;
        dec_qsel = 0; dec_imm = 0; dec_branch = 0; dec_jump = 0; dec_target = 0;
        queue_full = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        cdb_branch = 0; cdb_taken = 0;
    endtask

    task automatic set_instr(input int rs1, input int rs2, input int rd, input bit we,
                             input int qsel);
        ifq_valid = 1; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2); dec_rd = 5'(rd);
        dec_rd_we = we; dec_qsel = 2'(qsel); dec_imm = 32'hC000 + 32'(rd);
        dec_branch = 0; dec_jump = 0;
    endtask

    task automatic free_tag(input int tag, input logic [31:0] data);
        cdb_valid = 1; cdb_branch = 0; cdb_tag = 6'(tag); cdb_data = data;
        for (int i = 0; i < inflight.size(); i++) begin
            if (inflight[i] == tag) begin
                inflight.delete(i);
                break;
            end
        end
    endtask

    // One clock: predict, compare combinational outputs mid-cycle, advance the
    // model at the edge, then compare registered outputs.
    task automatic step();
        bit          cfree, alloc, fire, hz, exp_rfwe;
        int          exp_waddr, tag_out;
        int          a [2];
        bit          s_rdy [2];
        int          s_tag [2];
        logic [31:0] s_data [2];
        logic [3:0]  exp_dv;

        cfree = cdb_valid && !cdb_branch;
        a[0]  = int'(dec_rs1);
        a[1]  = int'(dec_rs2);
        hz    = 0;
        for (int s = 0; s < 2; s++) begin
            s_rdy[s] = 1; s_tag[s] = 0; s_data[s] = 0;
            if (a[s] != 0) begin
                if (m_rst[a[s]] >= 0) begin
                    if (cfree && m_rst[a[s]] == int'(cdb_tag)) begin
`ifdef RENAME_CDB_BYPASS_EN
                        s_data[s] = cdb_data;
`else
                        hz = 1;
`endif
                    end else begin
                        s_rdy[s] = 0;
                        s_tag[s] = m_rst[a[s]];
                    end
                end else begin
                    s_data[s] = rf_mem[a[s]];
                end
            end
        end
        alloc = dec_rd_we && dec_rd != 0;
        fire  = !rst && ifq_valid && m_mode == 0 && !queue_full[dec_qsel]
              && !(alloc && m_fl.size() == 0) && !hz;
        exp_rfwe  = 0;
        exp_waddr = 0;
        if (cfree && !rst) begin
            for (int r = 1; r < 32; r++) begin
                if (m_rst[r] == int'(cdb_tag)) begin
                    exp_rfwe  = 1;
                    exp_waddr = r;
                end
            end
        end

        @(negedge clk);
        obs_ren      = ifq_ren;
        obs_rf_we    = rf_we;
        obs_rf_waddr = rf_waddr;
        check("ifq_ren", 64'(ifq_ren), 64'(fire));
        check("rf_we", 64'(rf_we), 64'(exp_rfwe));
        if (exp_rfwe) check("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
        check("rf_raddr1", 64'(rf_raddr1), 64'(dec_rs1));

        @(posedge clk);
        #1;
        tag_out = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (fire && alloc) begin
                tag_out = m_fl.pop_front();
                inflight.push_back(tag_out);
            end
            if (exp_rfwe) begin
                rf_mem[exp_waddr] = cdb_data;
                m_rst[exp_waddr]  = -1;
            end
            if (fire && alloc) m_rst[dec_rd] = tag_out;
            if (cfree) m_fl.push_back(int'(cdb_tag));
            case (m_mode)
                0: begin
                    if (fire && dec_branch) begin
                        m_mode = 1; m_redir_addr = dec_target;
                    end else if (fire && dec_jump) begin
                        m_mode = 2; m_redir_addr = dec_target;
                    end
                end
                1: if (cdb_valid && cdb_branch) m_mode = cdb_taken ? 2 : 0;
                default: m_mode = 0;
            endcase
        end

        exp_dv = fire ? (4'b0001 << dec_qsel) : 4'b0000;
        check("disp_valid", 64'(disp_valid), 64'(exp_dv));
        check("redirect_valid", 64'(redirect_valid), 64'(m_mode == 2));
        if (m_mode == 2 || rst) check("redirect_addr", 64'(redirect_addr), 64'(m_redir_addr));
        if (rst) check("disp_pkt_reset", 64'(disp_pkt == '0), 64'(1));
        if (fire) begin
            check("rs1_rdy", 64'(disp_pkt.rs1.rdy), 64'(s_rdy[0]));
            check("rs1_tag", 64'(disp_pkt.rs1.tag), 64'(s_tag[0]));
            check("rs1_data", 64'(disp_pkt.rs1.data), 64'(s_data[0]));
            check("rs2_rdy", 64'(disp_pkt.rs2.rdy), 64'(s_rdy[1]));
            check("rs2_tag", 64'(disp_pkt.rs2.tag), 64'(s_tag[1]));
            check("rs2_data", 64'(disp_pkt.rs2.data), 64'(s_data[1]));
            check("rd_tag", 64'(disp_pkt.rd_tag), 64'(tag_out));
            check("rd_we", 64'(disp_pkt.rd_we), 64'(alloc));
            check("imm", 64'(disp_pkt.imm), 64'(dec_imm));
        end
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    typedef struct {
        bit          iv;
        int          rs1, rs2, rd;
        bit          we;
        int          qsel;
        logic [3:0]  qf;
        bit          cv;
        int          ctag;
        logic [31:0] cdata;
        bit          e_ren;
        bit          e_rfwe;
        int          e_waddr;
        logic [3:0]  e_dv;
        int          e_rdtag;
        bit          e_rs1rdy;
        logic [31:0] e_rs1val;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(bit iv, int rs1, int rs2, int rd, bit we, int qsel,
                                 logic [3:0] qf, bit cv, int ctag, logic [31:0] cdata,
                                 bit e_ren, bit e_rfwe, int e_waddr, logic [3:0] e_dv,
                                 int e_rdtag, bit e_rs1rdy, logic [31:0] e_rs1val);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.qsel = qsel;
        v.qf = qf; v.cv = cv; v.ctag = ctag; v.cdata = cdata;
        v.e_ren = e_ren; v.e_rfwe = e_rfwe; v.e_waddr = e_waddr; v.e_dv = e_dv;
        v.e_rdtag = e_rdtag; v.e_rs1rdy = e_rs1rdy; v.e_rs1val = e_rs1val;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   n;
        logic [3:0] qf;

        for (int r = 0; r < 32; r++) rf_mem[r] = (r == 0) ? 32'h0 : 32'h100 + 32'(r);
        model_reset();
        set_idle();

        // Rows: inputs ... | ren, rf_we, waddr, disp_valid, rd_tag, rs1 rdy, rs1 data-or-tag
        vecs.push_back(mkv(1, 1, 2, 5, 1, 0, 4'b0, 0, 0, 0,      1, 0, 0, 4'b0001, 0, 1, 32'h101));
        vecs.push_back(mkv(1, 3, 4, 7, 1, 0, 4'b0, 0, 0, 0,      1, 0, 0, 4'b0001, 1, 1, 32'h103));
        vecs.push_back(mkv(1, 5, 2, 6, 1, 0, 4'b0, 0, 0, 0,      1, 0, 0, 4'b0001, 2, 0, 32'h0));
        vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 4'b0, 1, 0, 32'h7,  0, 1, 5, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 5, 0, 8, 1, 0, 4'b0, 0, 0, 0,      1, 0, 0, 4'b0001, 3, 1, 32'h7));
`ifdef RENAME_CDB_BYPASS_EN
        vecs.push_back(mkv(1, 7, 0, 9, 1, 0, 4'b0, 1, 1, 32'h55, 1, 1, 7, 4'b0001, 4, 1, 32'h55));
        vecs.push_back(mkv(1, 7, 0, 9, 1, 0, 4'b0, 0, 0, 0,      1, 0, 0, 4'b0001, 5, 1, 32'h55));
        vecs.push_back(mkv(1, 1, 1, 10, 1, 2, 4'b0100, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 1, 1, 10, 1, 0, 4'b0100, 0, 0, 0,  1, 0, 0, 4'b0001, 6, 1, 32'h101));
`else
        vecs.push_back(mkv(1, 7, 0, 9, 1, 0, 4'b0, 1, 1, 32'h55, 0, 1, 7, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 7, 0, 9, 1, 0, 4'b0, 0, 0, 0,      1, 0, 0, 4'b0001, 4, 1, 32'h55));
        vecs.push_back(mkv(1, 1, 1, 10, 1, 2, 4'b0100, 0, 0, 0,  0, 0, 0, 4'b0000, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 1, 1, 10, 1, 0, 4'b0100, 0, 0, 0,  1, 0, 0, 4'b0001, 5, 1, 32'h101));
`endif

        do_reset();
        check("reset_disp_valid", 64'(disp_valid), 64'(0));
        check("reset_redirect", 64'(redirect_valid), 64'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            set_idle();
            if (v.iv) set_instr(v.rs1, v.rs2, v.rd, v.we, v.qsel);
            queue_full = v.qf;
            if (v.cv) free_tag(v.ctag, v.cdata);
            step();
            check($sformatf("vec%0d_ren", i), 64'(obs_ren), 64'(v.e_ren));
            check($sformatf("vec%0d_rf_we", i), 64'(obs_rf_we), 64'(v.e_rfwe));
            if (v.e_rfwe) check($sformatf("vec%0d_waddr", i), 64'(obs_rf_waddr), 64'(v.e_waddr));
            check($sformatf("vec%0d_dv", i), 64'(disp_valid), 64'(v.e_dv));
            if (v.e_dv != 0) begin
                check($sformatf("vec%0d_rd_tag", i), 64'(disp_pkt.rd_tag), 64'(v.e_rdtag));
                check($sformatf("vec%0d_rs1_rdy", i), 64'(disp_pkt.rs1.rdy), 64'(v.e_rs1rdy));
                check($sformatf("vec%0d_rs1_val", i),
                      v.e_rs1rdy ? 64'(disp_pkt.rs1.data) : 64'(disp_pkt.rs1.tag),
                      64'(v.e_rs1val));
            end
        end

        // Free-list exhaustion: 64 renames, then stall until a tag returns.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            set_idle();
            set_instr(0, 0, 1 + (i % 31), 1, 0);
            step();
        end
        step();
        check("fl_empty_stall", 64'(obs_ren), 64'(0));
        free_tag(3, 32'hAB);
        step();
        check("fl_push_no_bypass", 64'(obs_ren), 64'(0));
        cdb_valid = 0;
        step();
        check("fl_refill_ren", 64'(obs_ren), 64'(1));
        check("fl_refill_tag", 64'(disp_pkt.rd_tag), 64'(3));

        // Taken branch, not-taken branch, jump.
        do_reset();
        set_idle();
        set_instr(1, 2, 0, 0, 0);
        dec_branch = 1; dec_target = 32'h1234;
        step();
        check("br_fire", 64'(obs_ren), 64'(1));
        set_instr(1, 2, 3, 1, 0);
        step();
        check("br_wait_stall", 64'(obs_ren), 64'(0));
        cdb_valid = 1; cdb_branch = 1; cdb_taken = 1;
        step();
        check("br_resolve_ren", 64'(obs_ren), 64'(0));
        check("br_redirect_valid", 64'(redirect_valid), 64'(1));
        check("br_redirect_addr", 64'(redirect_addr), 64'(32'h1234));
        set_idle();
        set_instr(1, 2, 3, 1, 0);
        step();
        check("redirect_no_fire", 64'(obs_ren), 64'(0));
        check("redirect_pulse_end", 64'(redirect_valid), 64'(0));
        step();
        check("back_to_run", 64'(obs_ren), 64'(1));
        set_instr(1, 2, 0, 0, 0);
        dec_branch = 1; dec_target = 32'h2000;
        step();
        set_instr(4, 0, 5, 1, 1);
        cdb_valid = 1; cdb_branch = 1; cdb_taken = 0;
        step();
        check("nt_resolve_ren", 64'(obs_ren), 64'(0));
        check("nt_no_redirect", 64'(redirect_valid), 64'(0));
        set_idle();
        set_instr(4, 0, 5, 1, 1);
        step();
        check("nt_run_fire", 64'(obs_ren), 64'(1));
        set_instr(0, 0, 1, 1, 0);
        dec_jump = 1; dec_target = 32'h4000;
        step();
        check("jump_redirect_valid", 64'(redirect_valid), 64'(1));
        check("jump_redirect_addr", 64'(redirect_addr), 64'(32'h4000));
        set_idle();
        step();

        // Reset while waiting on a branch.
        do_reset();
        set_instr(1, 0, 3, 1, 0);
        step();
        set_instr(3, 0, 0, 0, 0);
        dec_branch = 1; dec_target = 32'h3000;
        step();
        set_instr(1, 0, 4, 1, 0);
        rst = 1;
        step();
        rst = 0;
        step();
        check("rst_brwait_ren", 64'(obs_ren), 64'(1));
        check("rst_brwait_tag", 64'(disp_pkt.rd_tag), 64'(0));

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            if ($urandom_range(0, 99) < 75) begin
                set_instr($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 9),
                          1'($urandom_range(0, 99) < 70), $urandom_range(0, 3));
                dec_imm = $urandom;
                n = $urandom_range(0, 99);
                if (n < 5) begin
                    dec_branch = 1; dec_rd_we = 0;
                end else if (n < 8) begin
                    dec_jump = 1;
                end
                dec_target = $urandom;
            end
            qf = '0;
            for (int q = 0; q < 4; q++) qf[q] = ($urandom_range(0, 9) == 0);
            queue_full = qf;
            if (m_mode == 1 && $urandom_range(0, 1) == 1) begin
                cdb_valid = 1; cdb_branch = 1; cdb_taken = 1'($urandom_range(0, 1));
            end else if (inflight.size() > 0 && $urandom_range(0, 99) < 40) begin
                free_tag(inflight[$urandom_range(0, inflight.size() - 1)], $urandom);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
